// File: rtl/aes_encipher_block.sv
// aes_encipher_block
//   Iterative AES encipher datapath. It runs the initial AddRoundKey, Nr-1 full
//   rounds and the final round on one 128-bit block. SubBytes goes one 32-bit
//   word per cycle through a shared external S-box. It is followed by one cycle
//   of ShiftRows + MixColumns + AddRoundKey. Each round therefore takes 5 cycles.
//   Round keys come from an external key memory, which is addressed by 'round'.
//
// Ports
//   clk        in   1    clock, all state updates on the rising edge
//   reset      in   1    synchronous active-high reset
//   next       in   1    start pulse, only looked at while idle
//   keylen     in   1    0 = AES-128, 1 = AES-256, captured with next
//   round      out  4    round key address
//   round_key  in   128  round key for 'round', combinational
//   sboxw      out  32   word presented to the shared S-box
//   new_sboxw  in   32   S-box result for sboxw, combinational
//   block      in   128  plaintext, captured in the init cycle
//   new_block  out  128  state register, ciphertext once ready returns high
//   ready      out  1    idle / result valid

module aes_encipher_block #(
  parameter logic [3:0] AES128_ROUNDS = 4'ha,
  parameter logic [3:0] AES256_ROUNDS = 4'he
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_INIT = 2'd1;
  localparam logic [1:0] CTRL_SBOX = 2'd2;
  localparam logic [1:0] CTRL_MAIN = 2'd3;

  logic [1:0]   r_state;
  logic [127:0] r_block;
  logic [3:0]   r_round_ctr;
  logic [1:0]   r_sword_ctr;
  logic         r_keylen;
  logic         r_ready;

  logic [3:0]   w_num_rounds;
  logic [1:0]   w_sbox_sel;
  logic [127:0] w_sub_block;
  logic [127:0] w_shifted;
  logic [127:0] w_mixed;

  // GF(2^8) multiply by x, reduced by the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // MixColumns on one column, where the column is one 32-bit word with its top byte in row 0
  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  // ShiftRows on the column-major state. Row r of column c takes row r of column (c+r)%4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [31:0] c0, c1, c2, c3;
    c0 = s[127:96];
    c1 = s[95:64];
    c2 = s[63:32];
    c3 = s[31:0];
    return {c0[31:24], c1[23:16], c2[15:8], c3[7:0],
            c1[31:24], c2[23:16], c3[15:8], c0[7:0],
            c2[31:24], c3[23:16], c0[15:8], c1[7:0],
            c3[31:24], c0[23:16], c1[15:8], c2[7:0]};
  endfunction

  assign w_num_rounds = r_keylen ? AES256_ROUNDS : AES128_ROUNDS;

  // Outside the S-box phase, sboxw is parked on word 0 so that it stays stable
  assign w_sbox_sel = (r_state == CTRL_SBOX) ? r_sword_ctr : 2'd0;

  always_comb begin
    sboxw = r_block[127:96];
    case (w_sbox_sel)
      2'd0: sboxw = r_block[127:96];
      2'd1: sboxw = r_block[95:64];
      2'd2: sboxw = r_block[63:32];
      2'd3: sboxw = r_block[31:0];
      default: sboxw = r_block[127:96];
    endcase
  end

  // Splice the substituted word back into the state
  always_comb begin
    w_sub_block = r_block;
    case (r_sword_ctr)
      2'd0: w_sub_block[127:96] = new_sboxw;
      2'd1: w_sub_block[95:64]  = new_sboxw;
      2'd2: w_sub_block[63:32]  = new_sboxw;
      2'd3: w_sub_block[31:0]   = new_sboxw;
      default: w_sub_block = r_block;
    endcase
  end

  assign w_shifted = shift_rows(r_block);
  assign w_mixed   = {mix_word(w_shifted[127:96]), mix_word(w_shifted[95:64]),
                      mix_word(w_shifted[63:32]),  mix_word(w_shifted[31:0])};

  // Round control and state update. round_ctr doubles as the key memory address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CTRL_IDLE;
      r_block     <= '0;
      r_round_ctr <= '0;
      r_sword_ctr <= '0;
      r_keylen    <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        CTRL_IDLE: begin
          if (next) begin
            r_ready     <= 1'b0;
            r_keylen    <= keylen;
            r_round_ctr <= 4'd0;
            r_state     <= CTRL_INIT;
          end
        end
        CTRL_INIT: begin
          r_block     <= block ^ round_key;
          r_round_ctr <= 4'd1;
          r_sword_ctr <= 2'd0;
          r_state     <= CTRL_SBOX;
        end
        CTRL_SBOX: begin
          r_block     <= w_sub_block;
          r_sword_ctr <= r_sword_ctr + 2'd1;
          if (r_sword_ctr == 2'd3) begin
            r_state <= CTRL_MAIN;
          end
        end
        CTRL_MAIN: begin
          if (r_round_ctr < w_num_rounds) begin
            r_block     <= w_mixed ^ round_key;
            r_round_ctr <= r_round_ctr + 4'd1;
            r_state     <= CTRL_SBOX;
          end else begin
            // Final round skips MixColumns
            r_block     <= w_shifted ^ round_key;
            r_ready     <= 1'b1;
            r_round_ctr <= 4'd0;
            r_state     <= CTRL_IDLE;
          end
        end
        default: r_state <= CTRL_IDLE;
      endcase
    end
  end

  assign round     = r_round_ctr;
  assign new_block = r_block;
  assign ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_block.sv
// tb_aes_encipher_block
//   Bench for aes_encipher_block. The bench plays two parts: the shared S-box
//   and the key memory. Both are built from first principles (a GF(2^8)
//   inverse plus the affine map, and the FIPS-197 key schedule). Expected
//   ciphertexts are the FIPS-197 published vectors. They are queued when a run
//   is launched and compared when ready rises.

module tb_aes_encipher_block;

   logic         clk;
   logic         reset;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] roundKey;
   logic [31:0]  sboxw;
   logic [31:0]  newSboxw;
   logic [127:0] block;
   logic [127:0] newBlock;
   logic         ready;

   logic [7:0]   sboxTab [0:255];
   logic [127:0] rkArr   [0:15];

   typedef struct {
      logic [127:0] ct;
      int           lat;
   } sbEntry_t;

   sbEntry_t sbQueue [$];

   int checks;
   int errors;
   int lowCnt;
   bit prevReady;

   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_encipher_block dut (
      .clk       (clk),
      .reset     (reset),
      .next      (next),
      .keylen    (keylen),
      .round     (round),
      .round_key (roundKey),
      .sboxw     (sboxw),
      .new_sboxw (newSboxw),
      .block     (block),
      .new_block (newBlock),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key memory and S-box are combinational, just like the real neighbours
   assign roundKey = rkArr[round];
   assign newSboxw = {sboxTab[sboxw[31:24]], sboxTab[sboxw[23:16]],
                      sboxTab[sboxw[15:8]],  sboxTab[sboxw[7:0]]};

   function automatic logic [7:0] tbXtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = tbXtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // Multiplicative inverse followed by the affine transform
   function automatic logic [7:0] sboxCalc(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
   endfunction

   // FIPS-197 key schedule that fills the key memory. An AES-128 key sits in the top half.
   task automatic expandKey(input logic [255:0] key, input logic kl);
      logic [31:0] w [0:59];
      logic [31:0] temp;
      logic [7:0]  rc;
      int nk;
      int total;
      nk    = kl ? 8 : 4;
      total = kl ? 60 : 44;
      rc    = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < total; i++) begin
         temp = w[i-1];
         if (i % nk == 0) begin
            temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
            rc   = tbXtime(rc);
         end else if (nk == 8 && i % nk == 4) begin
            temp = subWord(temp);
         end
         w[i] = w[i-nk] ^ temp;
      end
      for (int r = 0; r < 16; r++) begin
         if (r < 15) rkArr[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else        rkArr[r] = 128'h0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic waitCycle();
      @(negedge clk);
      #1;
   endtask

   // Scoreboard consumer: a rising ready retires the oldest queued run
   always @(negedge clk) begin
      sbEntry_t e;
      if (reset) begin
         prevReady = 1'b1;
         lowCnt    = 0;
      end else begin
         if (!ready) begin
            lowCnt++;
         end else if (!prevReady) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpectedDone", 128'd1, 128'd0);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("ciphertext", newBlock, e.ct);
               checkOutput("readyLowCycles", 128'(lowCnt), 128'(e.lat));
            end
            lowCnt = 0;
         end
         prevReady = ready;
      end
   end

   // Launch one run and follow it to completion. Block and keylen are scrambled
   // mid-run, next is optionally pulsed while busy, and the round address is tracked.
   task automatic applyStimulus(input logic [255:0] key, input logic kl, input logic [127:0] pt,
                                input logic [127:0] ct, input bit pulses);
      sbEntry_t e;
      int nr;
      int cyc;
      int prevRound;
      int maxRound;
      int viol;
      nr = kl ? 14 : 10;
      expandKey(key, kl);
      keylen = kl;
      block  = pt;
      next   = 1'b1;
      e.ct   = ct;
      e.lat  = 1 + 5*nr;
      sbQueue.push_back(e);
      waitCycle();
      next      = 1'b0;
      cyc       = 0;
      prevRound = 0;
      maxRound  = 0;
      viol      = 0;
      while (!ready && cyc < 200) begin
         if (int'(round) != prevRound && int'(round) != prevRound + 1) viol++;
         prevRound = int'(round);
         if (prevRound > maxRound) maxRound = prevRound;
         if (cyc >= 1) begin
            block  = {$urandom, $urandom, $urandom, $urandom};
            keylen = ~kl;
         end
         if (pulses) next = (cyc == 5 || cyc == 20 || cyc == 40);
         waitCycle();
         cyc++;
      end
      next = 1'b0;
      if (!ready) begin
         checkOutput("readyTimeout", 128'd0, 128'd1);
         sbQueue.delete();
      end
      checkOutput("roundStep", 128'(viol), 128'd0);
      checkOutput("roundMax", 128'(maxRound), 128'(nr));
   endtask

   // Mid-run abort: reset during round 4 must clear everything in one edge
   task automatic resetAbort();
      sbEntry_t e;
      int cyc;
      expandKey(KEY_C1, 1'b0);
      keylen = 1'b0;
      block  = PT_C;
      next   = 1'b1;
      e.ct   = CT_C1;
      e.lat  = 51;
      sbQueue.push_back(e);
      waitCycle();
      next = 1'b0;
      cyc  = 0;
      while (round != 4'd4 && cyc < 200) begin
         waitCycle();
         cyc++;
      end
      checkOutput("reachRound4", 128'(round), 128'd4);
      reset = 1'b1;
      sbQueue.delete();
      waitCycle();
      checkOutput("abortReady", 128'(ready), 128'd1);
      checkOutput("abortNewBlock", newBlock, 128'd0);
      checkOutput("abortRound", 128'(round), 128'd0);
      reset = 1'b0;
   endtask

   // Two runs with next held high throughout: the second starts on the first ready cycle
   task automatic backToBack();
      sbEntry_t e;
      int cyc;
      expandKey(KEY_C1, 1'b0);
      keylen = 1'b0;
      block  = PT_C;
      next   = 1'b1;
      e.ct   = CT_C1;
      e.lat  = 51;
      sbQueue.push_back(e);
      waitCycle();
      checkOutput("b2bFirstStart", 128'(ready), 128'd0);
      cyc = 0;
      while (!ready && cyc < 200) begin
         waitCycle();
         cyc++;
      end
      checkOutput("b2bFirstDone", 128'(ready), 128'd1);
      expandKey(KEY_C3, 1'b1);
      keylen = 1'b1;
      e.ct   = CT_C3;
      e.lat  = 71;
      sbQueue.push_back(e);
      waitCycle();
      checkOutput("b2bSecondStart", 128'(ready), 128'd0);
      waitCycle();
      next = 1'b0;
      cyc  = 0;
      while (!ready && cyc < 200) begin
         waitCycle();
         cyc++;
      end
      checkOutput("b2bSecondDone", 128'(ready), 128'd1);
      if (!ready) sbQueue.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      next   = 1'b0;
      keylen = 1'b0;
      block  = '0;
      for (int i = 0; i < 256; i++) sboxTab[i] = sboxCalc(8'(i));
      for (int r = 0; r < 16; r++) rkArr[r] = 128'h0;
      $display("[TB] S-box check: sbox(00)=%h sbox(53)=%h", sboxTab[8'h00], sboxTab[8'h53]);
      checkOutput("sboxTable", {sboxTab[8'h00], sboxTab[8'h53]}, 128'h63ed);

      repeat (3) waitCycle();
      checkOutput("resetReady", 128'(ready), 128'd1);
      checkOutput("resetNewBlock", newBlock, 128'd0);
      checkOutput("resetRound", 128'(round), 128'd0);
      reset = 1'b0;
      waitCycle();
      checkOutput("idleReady", 128'(ready), 128'd1);

      applyStimulus(KEY_B,  1'b0, PT_B, CT_B,  1'b0);
      applyStimulus(KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);
      applyStimulus(KEY_C3, 1'b1, PT_C, CT_C3, 1'b0);
      applyStimulus(KEY_C1, 1'b0, PT_C, CT_C1, 1'b1);

      repeat (3) waitCycle();
      checkOutput("idleHold", newBlock, CT_C1);
      checkOutput("idleStillReady", 128'(ready), 128'd1);

      resetAbort();
      waitCycle();
      applyStimulus(KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);

      backToBack();

      repeat (3) waitCycle();
      checkOutput("scoreboardEmpty", 128'(sbQueue.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
